// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller beside the D/E register: load-use stall
// sequencing, branch-redirect flushes and EX operand-forwarding selects.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_control_unit #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       de_rd,
  input  logic [4:0]       de_rs1,
  input  logic [4:0]       de_rs2,
  input  logic             de_is_load,
  input  logic             de_reg_write,
  input  logic [4:0]       em_rd,
  input  logic             em_reg_write,
  input  logic [4:0]       mw_rd,
  input  logic             mw_reg_write,
  input  logic             ex_redirect,
  output logic             pc_stall,
  output logic             fd_stall,
  output logic             fd_flush,
  output logic             de_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] STALL_RELOAD = CW'(LOAD_STALL_CYCLES - 1);

  typedef enum logic {RUN, LSTALL} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          w_hazard;

  assign w_hazard = de_is_load & de_reg_write & (de_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == de_rd)) |
                     (id_uses_rs2 & (id_rs2 == de_rd)));

  // Stall/flush controls from state and inputs; forced low while in reset
  always_comb begin
    pc_stall = 1'b0;
    fd_stall = 1'b0;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    if (reset) begin
      if (ex_redirect) begin
        fd_flush = 1'b1;
        de_flush = 1'b1;
      end else if ((r_state == LSTALL) || w_hazard) begin
        pc_stall = 1'b1;
        fd_stall = 1'b1;
        de_flush = 1'b1;
      end
    end
  end

  // Load-use bubble sequencer; redirect aborts any stall in progress
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (!ex_redirect && w_hazard && (LOAD_STALL_CYCLES > 1)) begin
            r_state <= LSTALL;
            r_cnt   <= STALL_RELOAD;
          end
        end
        LSTALL: begin
          if (ex_redirect || (r_cnt == CW'(1))) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Operand forwarding: E/M beats M/W, x0 never forwarded
  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (em_reg_write && (em_rd != 5'd0) && (em_rd == de_rs1)) begin
      fwd_a_sel = 2'b01;
    end else if (mw_reg_write && (mw_rd != 5'd0) && (mw_rd == de_rs1)) begin
      fwd_a_sel = 2'b10;
    end
    if (em_reg_write && (em_rd != 5'd0) && (em_rd == de_rs2)) begin
      fwd_b_sel = 2'b01;
    end else if (mw_reg_write && (mw_rd != 5'd0) && (mw_rd == de_rs2)) begin
      fwd_b_sel = 2'b10;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  // Saturating stall-cycle and flush-event counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (pc_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (fd_flush && (r_flush_events != '1)) begin
        r_flush_events <= r_flush_events + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: one instance with a single-bubble stall and
// one with a three-bubble stall (narrow counters so saturation is reached),
// both checked every cycle against a remaining-bubbles reference model.
module tb_hazard_control_unit;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, de_rd, de_rs1, de_rs2, em_rd, mw_rd;
  logic       id_uses_rs1, id_uses_rs2, de_is_load, de_reg_write;
  logic       em_reg_write, mw_reg_write, ex_redirect;

  logic       pc_s [2];
  logic       fd_s [2];
  logic       fd_f [2];
  logic       de_f [2];
  logic [1:0] fa   [2];
  logic [1:0] fb   [2];
  logic [31:0] sc1, fe1;
  logic [2:0]  sc3, fe3;

  int checks   = 0;
  int failures = 0;

  // Reference state: bubbles still owed and counter values per instance
  int     m_rem [2];
  longint m_sc  [2];
  longint m_fe  [2];
  int     lcyc  [2] = '{1, 3};
  longint cmax  [2] = '{64'hFFFF_FFFF, 64'd7};
  bit     e_st  [2];
  bit     e_fl  [2];

  always #5 clock = ~clock;

  hazard_control_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) u1 (
    .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .de_rd(de_rd),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .de_is_load(de_is_load),
    .de_reg_write(de_reg_write), .em_rd(em_rd), .em_reg_write(em_reg_write),
    .mw_rd(mw_rd), .mw_reg_write(mw_reg_write), .ex_redirect(ex_redirect),
    .pc_stall(pc_s[0]), .fd_stall(fd_s[0]), .fd_flush(fd_f[0]),
    .de_flush(de_f[0]), .fwd_a_sel(fa[0]), .fwd_b_sel(fb[0]),
    .stall_cycles(sc1), .flush_events(fe1));

  hazard_control_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(3)) u3 (
    .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .de_rd(de_rd),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .de_is_load(de_is_load),
    .de_reg_write(de_reg_write), .em_rd(em_rd), .em_reg_write(em_reg_write),
    .mw_rd(mw_rd), .mw_reg_write(mw_reg_write), .ex_redirect(ex_redirect),
    .pc_stall(pc_s[1]), .fd_stall(fd_s[1]), .fd_flush(fd_f[1]),
    .de_flush(de_f[1]), .fwd_a_sel(fa[1]), .fwd_b_sel(fb[1]),
    .stall_cycles(sc3), .flush_events(fe3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hazard();
    if (!(de_is_load && de_reg_write) || de_rd == 5'd0) return 1'b0;
    return (id_uses_rs1 && id_rs1 == de_rd) || (id_uses_rs2 && id_rs2 == de_rd);
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (em_reg_write && em_rd == rs) return 2'b01;
    if (mw_reg_write && mw_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 2; d++) begin
      m_rem[d] = 0; m_sc[d] = 0; m_fe[d] = 0;
    end
  endfunction

  // Compare every output of both instances against the model right now
  task automatic check_now(input string ph);
    bit hz;
    logic [31:0] osc, ofe;
    if (!reset) model_clear();
    hz = model_hazard();
    for (int d = 0; d < 2; d++) begin
      e_fl[d] = reset && ex_redirect;
      e_st[d] = reset && !ex_redirect && (m_rem[d] > 0 || hz);
      osc = (d == 0) ? sc1 : 32'(sc3);
      ofe = (d == 0) ? fe1 : 32'(fe3);
      chk($sformatf("%s[L%0d].pc_stall", ph, lcyc[d]), 32'(pc_s[d]), 32'(e_st[d]));
      chk($sformatf("%s[L%0d].fd_stall", ph, lcyc[d]), 32'(fd_s[d]), 32'(e_st[d]));
      chk($sformatf("%s[L%0d].fd_flush", ph, lcyc[d]), 32'(fd_f[d]), 32'(e_fl[d]));
      chk($sformatf("%s[L%0d].de_flush", ph, lcyc[d]), 32'(de_f[d]), 32'(e_st[d] | e_fl[d]));
      chk($sformatf("%s[L%0d].fwd_a", ph, lcyc[d]), 32'(fa[d]), 32'(model_fwd(de_rs1)));
      chk($sformatf("%s[L%0d].fwd_b", ph, lcyc[d]), 32'(fb[d]), 32'(model_fwd(de_rs2)));
      chk($sformatf("%s[L%0d].stall_cycles", ph, lcyc[d]), osc, PERF ? 32'(m_sc[d]) : 32'd0);
      chk($sformatf("%s[L%0d].flush_events", ph, lcyc[d]), ofe, PERF ? 32'(m_fe[d]) : 32'd0);
    end
  endtask

  // One clock: check mid-cycle, then advance the model at the rising edge
  task automatic step(input string ph);
    bit hz;
    @(negedge clock);
    check_now(ph);
    hz = model_hazard();
    @(posedge clock);
    if (!reset) begin
      model_clear();
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (e_st[d] && m_sc[d] < cmax[d]) m_sc[d]++;
        if (e_fl[d] && m_fe[d] < cmax[d]) m_fe[d]++;
        if (ex_redirect)     m_rem[d] = 0;
        else if (m_rem[d] > 0) m_rem[d]--;
        else if (hz)         m_rem[d] = lcyc[d] - 1;
      end
    end
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    de_rd = 0; de_rs1 = 0; de_rs2 = 0; de_is_load = 0; de_reg_write = 0;
    em_rd = 0; em_reg_write = 0; mw_rd = 0; mw_reg_write = 0; ex_redirect = 0;
  endtask

  task automatic load_hazard();
    de_is_load = 1; de_reg_write = 1; de_rd = 5'd5;
    id_uses_rs1 = 1; id_rs1 = 5'd5;
  endtask

  initial begin
    model_clear();
    idle();
    reset = 1'b0;
    step("reset");
    step("reset2");
    reset = 1'b1;
    step("idle");

    // Load-use hazard held for one cycle, then the bubble clears D/E
    load_hazard();
    step("lu_c1");
    idle();
    step("lu_c2");
    step("lu_c3");
    step("lu_c4");

    // Redirect on the second bubble of the long stall
    load_hazard();
    step("rd_c1");
    idle();
    ex_redirect = 1;
    step("rd_c2");
    ex_redirect = 0;
    step("rd_c3");

    // Forwarding priority and x0 suppression
    em_rd = 7; em_reg_write = 1; mw_rd = 7; mw_reg_write = 1; de_rs1 = 7; de_rs2 = 7;
    step("fwd_em");
    em_reg_write = 0;
    step("fwd_mw");
    em_reg_write = 1; em_rd = 0; mw_rd = 0; de_rs1 = 0; de_rs2 = 0;
    step("fwd_x0");
    idle();

    // Loads that must not stall
    load_hazard(); de_rd = 0; id_rs1 = 0;
    step("rd0");
    load_hazard(); de_reg_write = 0;
    step("nowr");
    idle();

    // Reset asserted in the middle of a long stall
    load_hazard();
    step("rs_c1");
    idle();
    step("rs_c2");
    load_hazard();
    reset = 1'b0;
    #1;
    check_now("rs_async");
    idle();
    step("rs_hold");
    reset = 1'b1;
    step("rs_after1");
    step("rs_after2");
    step("rs_after3");

    // Randomized traffic over a small register pool so hazards are frequent
    for (int n = 0; n < 400; n++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
      de_rd = 5'($urandom_range(0, 3)); de_rs1 = 5'($urandom_range(0, 3));
      de_rs2 = 5'($urandom_range(0, 3));
      de_is_load = 1'($urandom); de_reg_write = 1'($urandom_range(0, 3) != 0);
      em_rd = 5'($urandom_range(0, 3)); em_reg_write = 1'($urandom);
      mw_rd = 5'($urandom_range(0, 3)); mw_reg_write = 1'($urandom);
      ex_redirect = ($urandom_range(0, 7) == 0);
      if (n == 200) reset = 1'b0;
      if (n == 202) reset = 1'b1;
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
